// File: rtl/bundle_responder.sv
// ============================================================================
// bundle_responder : valid/ready request responder over a small register array
// Revision         : 1.0
// ============================================================================
`default_nettype none

module bundle_responder #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 2,
  parameter int DEPTH        = 4,
  parameter int STALL_CYCLES = 0,
  parameter int CNT_W        = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_bits_write,
  input  logic [ADDR_W-1:0] req_bits_addr,
  input  logic [DATA_W-1:0] req_bits_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_bits_data,
  output logic              resp_bits_err,
  output logic [CNT_W-1:0]  txn_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESP  = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  localparam int                 STALL_W    = (STALL_CYCLES < 2) ? 1 : $clog2(STALL_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(STALL_CYCLES);
  localparam logic [ADDR_W:0]    DEPTH_EXT  = (ADDR_W + 1)'(DEPTH);

  function automatic logic [DATA_W-1:0] init_val(input int idx);
    return DATA_W'((idx + 1) * 16);
  endfunction

  state_t              state_q, state_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                resp_err_q, resp_err_d;
  logic                resp_valid_q, resp_valid_d;
  logic                req_ready_q, req_ready_d;
  logic [CNT_W-1:0]    txn_count_q, txn_count_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  logic                req_fire;
  logic                addr_ok;
  logic [DATA_W-1:0]   rd_data;

  assign req_fire = req_valid && req_ready_q && (state_q == ST_IDLE);
  assign addr_ok  = ({1'b0, req_bits_addr} < DEPTH_EXT);

  // Read mux only spans the implemented entries; unimplemented indices read 0.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (req_bits_addr == ADDR_W'(i)) rd_data = mem_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    txn_count_d = txn_count_q;
    mem_d       = mem_q;

    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          state_d = ST_RESP;
          if (!addr_ok) begin
            resp_data_d = '0;
            resp_err_d  = 1'b1;
          end else if (req_bits_write) begin
            resp_data_d = req_bits_data;
            resp_err_d  = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
              if (req_bits_addr == ADDR_W'(i)) mem_d[i] = req_bits_data;
            end
          end else begin
            resp_data_d = rd_data;
            resp_err_d  = 1'b0;
          end
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          txn_count_d = txn_count_q + CNT_W'(1);
          if (STALL_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d     = ST_STALL;
            stall_cnt_d = STALL_LOAD;
          end
        end
      end
      ST_STALL: begin
        // Leaving on a count of 1 gives exactly STALL_CYCLES low-ready cycles.
        if (stall_cnt_q <= STALL_W'(1)) begin
          state_d = ST_IDLE;
        end else begin
          stall_cnt_d = stall_cnt_q - STALL_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      stall_cnt_q  <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      req_ready_q  <= 1'b0;
      txn_count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= init_val(i);
    end else begin
      state_q      <= state_d;
      stall_cnt_q  <= stall_cnt_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      resp_valid_q <= resp_valid_d;
      req_ready_q  <= req_ready_d;
      txn_count_q  <= txn_count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_bits_data = resp_data_q;
  assign resp_bits_err  = resp_err_q;
  assign txn_count      = txn_count_q;

endmodule

`default_nettype wire

// File: tb/tb_bundle_responder.sv
// ============================================================================
// tb_bundle_responder : directed vector bench for three bundle_responder configs
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_bundle_responder;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic       req_valid  [3];
  logic       req_ready  [3];
  logic       req_write  [3];
  logic [1:0] req_addr   [3];
  logic [7:0] req_data   [3];
  logic       resp_valid [3];
  logic       resp_ready [3];
  logic [7:0] resp_data  [3];
  logic       resp_err   [3];
  logic [15:0] txn0, txn1;
  logic [1:0]  txn2;

  // Instance 0: defaults. Instance 1: 3-cycle stall. Instance 2: DEPTH=3, 2-bit counter.
  bundle_responder u_dut0 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_bits_write(req_write[0]),
    .req_bits_addr(req_addr[0]), .req_bits_data(req_data[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_bits_data(resp_data[0]), .resp_bits_err(resp_err[0]), .txn_count(txn0));

  bundle_responder #(.STALL_CYCLES(3)) u_dut1 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_bits_write(req_write[1]),
    .req_bits_addr(req_addr[1]), .req_bits_data(req_data[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_bits_data(resp_data[1]), .resp_bits_err(resp_err[1]), .txn_count(txn1));

  bundle_responder #(.DEPTH(3), .CNT_W(2)) u_dut2 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_bits_write(req_write[2]),
    .req_bits_addr(req_addr[2]), .req_bits_data(req_data[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_bits_data(resp_data[2]), .resp_bits_err(resp_err[2]), .txn_count(txn2));

  typedef struct {
    int         d;
    logic       wr;
    logic [1:0] a;
    logic [7:0] wd;
    logic [7:0] ed;
    logic       ee;
  } vec_t;

  localparam int NV = 13;
  vec_t vt [NV];

  int n_vec = 0;
  int n_bad = 0;
  int exp_cnt [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out after 50 cycles", name);
  endtask

  function automatic logic [31:0] cnt_of(input int d);
    case (d)
      0:       return 32'(txn0);
      1:       return 32'(txn1);
      default: return 32'(txn2);
    endcase
  endfunction

  function automatic logic [31:0] exp_cnt_of(input int d);
    return (d == 2) ? 32'(exp_cnt[d] % 4) : 32'(exp_cnt[d] % 65536);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(input int d);
    int n = 0;
    while (req_ready[d] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) timeout("req_ready");
  endtask

  task automatic wait_resp(input int d);
    int n = 0;
    while (resp_valid[d] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) timeout("resp_valid");
  endtask

  task automatic txn(input int d, input logic wr, input logic [1:0] a, input logic [7:0] wd,
                     output logic [7:0] rd, output logic er);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = a;
    req_data[d]  = wd;
    wait_ready(d);
    tick();
    req_valid[d]  = 1'b0;
    resp_ready[d] = 1'b1;
    wait_resp(d);
    rd = resp_data[d];
    er = resp_err[d];
    tick();
    resp_ready[d] = 1'b0;
    exp_cnt[d]++;
  endtask

  initial begin
    logic [7:0] rd;
    logic       er;

    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = '0;
      req_data[i] = '0; resp_ready[i] = 1'b0; exp_cnt[i] = 0;
    end

    vt[0]  = '{0, 1'b1, 2'd1, 8'hA5, 8'hA5, 1'b0};
    vt[1]  = '{0, 1'b0, 2'd1, 8'h00, 8'hA5, 1'b0};
    vt[2]  = '{0, 1'b0, 2'd0, 8'h00, 8'h10, 1'b0};
    vt[3]  = '{0, 1'b0, 2'd3, 8'h00, 8'h40, 1'b0};
    vt[4]  = '{2, 1'b1, 2'd3, 8'hFF, 8'h00, 1'b1};
    vt[5]  = '{2, 1'b0, 2'd0, 8'h00, 8'h10, 1'b0};
    vt[6]  = '{2, 1'b0, 2'd1, 8'h00, 8'h20, 1'b0};
    vt[7]  = '{2, 1'b0, 2'd2, 8'h00, 8'h30, 1'b0};
    vt[8]  = '{2, 1'b1, 2'd2, 8'h77, 8'h77, 1'b0};
    vt[9]  = '{2, 1'b0, 2'd2, 8'h00, 8'h77, 1'b0};
    vt[10] = '{1, 1'b0, 2'd1, 8'h00, 8'h20, 1'b0};
    vt[11] = '{1, 1'b1, 2'd0, 8'h5A, 8'h5A, 1'b0};
    vt[12] = '{1, 1'b0, 2'd0, 8'h00, 8'h5A, 1'b0};

    // Reset state
    tick(); tick();
    chk("rst req_ready", 32'(req_ready[0]), 0);
    chk("rst resp_valid", 32'(resp_valid[0]), 0);
    chk("rst resp_data", 32'(resp_data[0]), 0);
    chk("rst resp_err", 32'(resp_err[0]), 0);
    chk("rst txn_count", cnt_of(0), 0);
    reset_n = 1'b1;
    tick();

    // Read addr 2: response one cycle after accept
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 2'd2;
    wait_ready(0);
    tick();
    chk("lat resp_valid", 32'(resp_valid[0]), 1);
    chk("lat resp_data", 32'(resp_data[0]), 32'h30);
    chk("lat resp_err", 32'(resp_err[0]), 0);
    chk("lat req_ready", 32'(req_ready[0]), 0);
    req_valid[0] = 1'b0; resp_ready[0] = 1'b1;
    tick();
    resp_ready[0] = 1'b0;
    exp_cnt[0]++;
    chk("lat resp_valid drop", 32'(resp_valid[0]), 0);
    chk("lat txn_count", cnt_of(0), 1);

    for (int v = 0; v < NV; v++) begin
      txn(vt[v].d, vt[v].wr, vt[v].a, vt[v].wd, rd, er);
      chk($sformatf("vec%0d data", v), 32'(rd), 32'(vt[v].ed));
      chk($sformatf("vec%0d err", v), 32'(er), 32'(vt[v].ee));
      chk($sformatf("vec%0d txn_count", v), cnt_of(vt[v].d), exp_cnt_of(vt[v].d));
    end

    // Response held through five cycles of back-pressure
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 2'd0;
    wait_ready(0);
    tick();
    req_valid[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("hold%0d resp_valid", c), 32'(resp_valid[0]), 1);
      chk($sformatf("hold%0d resp_data", c), 32'(resp_data[0]), 32'h10);
      chk($sformatf("hold%0d req_ready", c), 32'(req_ready[0]), 0);
      tick();
    end
    resp_ready[0] = 1'b1;
    chk("hold final resp_valid", 32'(resp_valid[0]), 1);
    tick();
    resp_ready[0] = 1'b0;
    exp_cnt[0]++;
    chk("hold done resp_valid", 32'(resp_valid[0]), 0);
    chk("hold txn_count", cnt_of(0), exp_cnt_of(0));

    // Back-to-back reads with a 3-cycle stall; req_valid held high throughout
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 2'd2;
    wait_ready(1);
    for (int r = 0; r < 2; r++) begin
      tick();
      chk($sformatf("stall%0d resp_valid", r), 32'(resp_valid[1]), 1);
      chk($sformatf("stall%0d resp_data", r), 32'(resp_data[1]), 32'h30);
      chk($sformatf("stall%0d ready in resp", r), 32'(req_ready[1]), 0);
      resp_ready[1] = 1'b1;
      tick();
      resp_ready[1] = 1'b0;
      exp_cnt[1]++;
      if (r == 1) req_valid[1] = 1'b0;
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("stall%0d cyc%0d req_ready", r, c), 32'(req_ready[1]), 0);
        chk($sformatf("stall%0d cyc%0d resp_valid", r, c), 32'(resp_valid[1]), 0);
        tick();
      end
      chk($sformatf("stall%0d ready back", r), 32'(req_ready[1]), 1);
    end
    chk("stall txn_count", cnt_of(1), exp_cnt_of(1));

    // Reset while a response is pending
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 2'd1;
    wait_ready(0);
    tick();
    req_valid[0] = 1'b0;
    chk("rstmid resp_valid before", 32'(resp_valid[0]), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid resp_valid", 32'(resp_valid[0]), 0);
    chk("rstmid req_ready", 32'(req_ready[0]), 0);
    chk("rstmid txn_count", cnt_of(0), 0);
    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    tick(); tick();
    reset_n = 1'b1;
    txn(0, 1'b0, 2'd1, 8'h00, rd, er);
    chk("post-rst read data", 32'(rd), 32'h20);
    chk("post-rst txn_count", cnt_of(0), 1);
    txn(2, 1'b0, 2'd2, 8'h00, rd, er);
    chk("post-rst d3 read data", 32'(rd), 32'h30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
